ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the pipelined RV32I core. It sits between the decode stage and the memory stage.
- Consumes a decoded instruction plus operand values from decode.
- Computes ALU results, load/store addresses and branch/jump targets.
- Presents a registered result bundle to the memory stage.
- Uses the same valid/ack handshake on both sides.
- Issues a one-cycle redirect pulse for taken control transfers.

Parameters:
BITSIZE, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock, all state updates on rising edge
rstn_i  in  1  reset, asynchronous, active-low
halt_i  in  1  freeze all state; ack_o forced 0
valid_i  in  1  decode presents a valid instruction
ack_o  out  1  combinational; instruction consumed this cycle
instr_i  in  32  raw instruction word
pc_i  in  32  pc of instr_i
rs1_i  in  32  rs1 operand value
rs2_i  in  32  rs2 operand value
ack_i  in  1  memory stage consumed the output bundle
valid_o  out  1  output bundle valid
instr_o  out  32  registered instruction
result_o  out  32  ALU result / effective address / link target
rs2_o  out  32  registered rs2 (store data)
pc_o  out  32  registered pc
branch_o  out  1  one-cycle redirect pulse
branch_target_o  out  32  redirect pc, valid while branch_o=1

Behaviour:
- Reset (async, rstn_i=0): valid_o=0; instr_o, result_o, rs2_o, pc_o, branch_target_o = 0; branch_o=0.
- Accept condition:
  - accept = valid_i & (!valid_o | ack_i) & !halt_i & !branch_o.
  - ack_o = accept, combinational.
- Output valid update:
  - On accept: valid_o<=1 and all output fields are loaded next edge.
  - Else if ack_i and !halt_i: valid_o<=0, data fields hold.
  - Simultaneous ack_i and accept: new bundle replaces old; valid_o stays 1.
- Latency: 1 cycle, valid_i to valid_o.
- Immediates are decoded from instr_i: I, S, B, U, J, sign-extended per RV32I.
- result_o by opcode (instr_i[6:0]):
  - OP 0110011: ADD/SUB; SUB when funct7[5]=1. SLL/SRL/SRA; SRA when funct7[5]=1; shift amount rs2_i[4:0]. SLT signed, SLTU unsigned, XOR, OR, AND.
  - OP-IMM 0010011: same ops with imm_i. No SUBI. SRAI when instr[30]=1; shift amount instr[24:20].
  - LUI: imm_u.
  - AUIPC: pc_i+imm_u.
  - LOAD: rs1_i+imm_i.
  - STORE: rs1_i+imm_s.
  - JAL: pc_i+imm_j.
  - JALR: (rs1_i+imm_i) & ~1.
  - BRANCH: 0.
  - Any other opcode: result_o=0, instruction passed through unchanged.
- All arithmetic is modulo 2^32; overflow is ignored.
- Branch compare by funct3:
  - 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
  - 010 and 011: never taken.
- Redirect:
  - On accept of JAL, of JALR, or of a taken BRANCH: branch_o<=1 next edge.
  - branch_target_o target: JAL pc_i+imm_j; JALR (rs1_i+imm_i)&~1; BRANCH pc_i+imm_b.
  - branch_o is high exactly one unhalted cycle, then clears.
  - While branch_o=1, ack_o=0: the wrong-path instruction on valid_i is not consumed. Decode flushes on branch_o.
  - Not-taken branches produce no pulse.
  - Branches and jumps still produce a valid_o bundle, so the memory stage computes the link value.
- halt_i=1:
  - No register changes: valid_o, fields, branch_o and branch_target_o all hold.
  - A pending branch_o pulse is stretched until halt is released, then lasts one unhalted cycle.
- Reset mid-operation: all state clears immediately; no redirect is issued.
- Back-pressure: if valid_o=1 and ack_i=0, ack_o=0 and outputs stay stable.

Test Plan:
- ADD back-to-back: x1=5, x2=7, valid_i held with ack_i=1. Expect ack_o every cycle; result_o=12 one cycle after the first accept; valid_o stays 1 with no bubbles.
- SUB/SRA/SLT corners:
  - SUB 0-1 -> 0xFFFFFFFF.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF<1 -> 1; SLTU -> 0.
  - SRAI 0x80000000 by 4 -> 0xF8000000.
- Back-pressure: ack_i=0 with valid_o=1 and a new valid_i. Expect ack_o=0 and outputs unchanged for 3 cycles; raise ack_i and the new bundle is accepted the same cycle.
- Taken BEQ: pc=0x100, rs1=rs2=3, imm_b=-8. Expect branch_o=1 for one cycle with branch_target_o=0xF8; ack_o=0 during that cycle; not-taken BNE yields no pulse.
- JALR: rs1=0x2003, imm=4. Expect result_o=0x2006 and branch_target_o=0x2006; LOAD rs1=0x1000, imm=-4 -> result_o=0xFFC.
- halt_i asserted in the cycle a taken branch is accepted, then held 2 cycles. Expect no state change during halt, branch_o lasting one cycle after release, and an async reset mid-bundle clearing valid_o without a clock edge.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: decodes immediates, runs the ALU,
// forms load/store addresses and jump/branch targets, and hands a registered
// bundle to the memory stage over a valid/ack handshake. Taken control
// transfers raise a single-cycle redirect pulse.
module ex_stage #(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic               halt_i,
  input  logic               valid_i,
  output logic               ack_o,
  input  logic [BITSIZE-1:0] instr_i,
  input  logic [BITSIZE-1:0] pc_i,
  input  logic [BITSIZE-1:0] rs1_i,
  input  logic [BITSIZE-1:0] rs2_i,
  input  logic               ack_i,
  output logic               valid_o,
  output logic [BITSIZE-1:0] instr_o,
  output logic [BITSIZE-1:0] result_o,
  output logic [BITSIZE-1:0] rs2_o,
  output logic [BITSIZE-1:0] pc_o,
  output logic               branch_o,
  output logic [BITSIZE-1:0] branch_target_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign alt    = instr_i[30];

  // Sign-extended immediates for every RV32I format
  logic [BITSIZE-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Second ALU operand: register for OP, I-immediate for OP-IMM. For the
  // immediate shifts imm_i[4:0] is exactly instr[24:20].
  logic [BITSIZE-1:0] op_b;
  logic [4:0]         shamt;
  logic               is_sub;
  assign op_b   = (opcode == OPC_OP) ? rs2_i : imm_i;
  assign shamt  = op_b[4:0];
  assign is_sub = (opcode == OPC_OP) & alt;

  // Arithmetic shift kept in its own signed net so the ALU mux cannot
  // demote it to a logical shift.
  logic signed [BITSIZE-1:0] sra_res;
  assign sra_res = $signed(rs1_i) >>> shamt;

  logic [BITSIZE-1:0] jalr_sum, jalr_tgt;
  assign jalr_sum = rs1_i + imm_i;
  assign jalr_tgt = {jalr_sum[BITSIZE-1:1], 1'b0};

  logic [BITSIZE-1:0] alu_res;
  logic               br_taken;
  logic [BITSIZE-1:0] result_d, target_d;
  logic               redirect_d;
  logic               accept;

  // Shared ALU for OP and OP-IMM, selected by funct3
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = is_sub ? (rs1_i - op_b) : (rs1_i + op_b);
      3'b001:  alu_res = rs1_i << shamt;
      3'b010:  alu_res = {{(BITSIZE-1){1'b0}}, ($signed(rs1_i) < $signed(op_b))};
      3'b011:  alu_res = {{(BITSIZE-1){1'b0}}, (rs1_i < op_b)};
      3'b100:  alu_res = rs1_i ^ op_b;
      3'b101:  alu_res = alt ? $unsigned(sra_res) : (rs1_i >> shamt);
      3'b110:  alu_res = rs1_i | op_b;
      default: alu_res = rs1_i & op_b;
    endcase
  end

  // Branch condition; funct3 010/011 are never taken
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_i == rs2_i);
      3'b001:  br_taken = (rs1_i != rs2_i);
      3'b100:  br_taken = ($signed(rs1_i) < $signed(rs2_i));
      3'b101:  br_taken = !($signed(rs1_i) < $signed(rs2_i));
      3'b110:  br_taken = (rs1_i < rs2_i);
      3'b111:  br_taken = !(rs1_i < rs2_i);
      default: br_taken = 1'b0;
    endcase
  end

  // Result, redirect request and redirect target by opcode
  always_comb begin
    result_d   = '0;
    redirect_d = 1'b0;
    target_d   = pc_i + imm_b;
    case (opcode)
      OPC_OP, OPC_OP_IMM: result_d = alu_res;
      OPC_LUI:            result_d = imm_u;
      OPC_AUIPC:          result_d = pc_i + imm_u;
      OPC_LOAD:           result_d = rs1_i + imm_i;
      OPC_STORE:          result_d = rs1_i + imm_s;
      OPC_JAL: begin
        result_d   = pc_i + imm_j;
        target_d   = pc_i + imm_j;
        redirect_d = 1'b1;
      end
      OPC_JALR: begin
        result_d   = jalr_tgt;
        target_d   = jalr_tgt;
        redirect_d = 1'b1;
      end
      OPC_BRANCH:         redirect_d = br_taken;
      default:            result_d = '0;
    endcase
  end

  // Output register state
  logic               valid_q, branch_q;
  logic [BITSIZE-1:0] instr_q, result_q, rs2_q, pc_q, target_q;

  // A redirect in flight blocks intake so the wrong-path instruction stays
  // with decode, which flushes it on the pulse.
  assign accept = valid_i & (!valid_q | ack_i) & !halt_i & !branch_q;
  assign ack_o  = accept;

  // Bundle, valid and redirect registers; halt freezes everything
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      result_q <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      branch_q <= 1'b0;
      target_q <= '0;
    end else if (!halt_i) begin
      if (accept) begin
        valid_q  <= 1'b1;
        instr_q  <= instr_i;
        result_q <= result_d;
        rs2_q    <= rs2_i;
        pc_q     <= pc_i;
        branch_q <= redirect_d;
        if (redirect_d) begin
          target_q <= target_d;
        end
      end else begin
        if (ack_i) begin
          valid_q <= 1'b0;
        end
        branch_q <= 1'b0;
      end
    end
  end

  assign valid_o         = valid_q;
  assign instr_o         = instr_q;
  assign result_o        = result_q;
  assign rs2_o           = rs2_q;
  assign pc_o            = pc_q;
  assign branch_o        = branch_q;
  assign branch_target_o = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a table of hand-computed vectors, hand-written
// handshake/halt/reset sequences, and random instructions checked against
// a field-level reference model.
module tb_ex_stage;

  logic        clk, rstn_i, halt_i, valid_i, ack_o, ack_i;
  logic [31:0] instr_i, pc_i, rs1_i, rs2_i;
  logic        valid_o, branch_o;
  logic [31:0] instr_o, result_o, rs2_o, pc_o, branch_target_o;

  int n_vec = 0;
  int n_err = 0;

  ex_stage #(.BITSIZE(32)) dut (
    .clk(clk), .rstn_i(rstn_i), .halt_i(halt_i), .valid_i(valid_i), .ack_o(ack_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .ack_i(ack_i),
    .valid_o(valid_o), .instr_o(instr_o), .result_o(result_o), .rs2_o(rs2_o),
    .pc_o(pc_o), .branch_o(branch_o), .branch_target_o(branch_target_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_LUI, K_AUIPC, K_LOAD, K_STORE, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_BR010, K_BR011, K_OTHER
  } kind_e;

  typedef struct {
    kind_e       k;
    logic [31:0] a, b, imm, pc;
    logic [31:0] exp_res;
    logic        exp_br;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input kind_e k, input logic [31:0] a, b, imm, pc, er,
                              input logic eb, input logic [31:0] et);
    vec_t v;
    v.k = k; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.exp_res = er; v.exp_br = eb; v.exp_tgt = et;
    return v;
  endfunction

  // Encoders: rs1=x1, rs2=x2, rd=x3
  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction
  function automatic logic [31:0] i_enc(input logic [11:0] im, input logic [2:0] f3, input logic [6:0] op);
    return {im, 5'd1, f3, 5'd3, op};
  endfunction
  function automatic logic [31:0] b_enc(input logic [31:0] im, input logic [2:0] f3);
    return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] encode(input kind_e k, input logic [31:0] im, input logic [31:0] rnd);
    logic [31:0] ins;
    ins = 32'h0;
    case (k)
      K_ADD:   ins = r_enc(7'h00, 3'd0);
      K_SUB:   ins = r_enc(7'h20, 3'd0);
      K_SLL:   ins = r_enc(7'h00, 3'd1);
      K_SLT:   ins = r_enc(7'h00, 3'd2);
      K_SLTU:  ins = r_enc(7'h00, 3'd3);
      K_XOR:   ins = r_enc(7'h00, 3'd4);
      K_SRL:   ins = r_enc(7'h00, 3'd5);
      K_SRA:   ins = r_enc(7'h20, 3'd5);
      K_OR:    ins = r_enc(7'h00, 3'd6);
      K_AND:   ins = r_enc(7'h00, 3'd7);
      K_ADDI:  ins = i_enc(im[11:0], 3'd0, 7'h13);
      K_SLTI:  ins = i_enc(im[11:0], 3'd2, 7'h13);
      K_SLTIU: ins = i_enc(im[11:0], 3'd3, 7'h13);
      K_XORI:  ins = i_enc(im[11:0], 3'd4, 7'h13);
      K_ORI:   ins = i_enc(im[11:0], 3'd6, 7'h13);
      K_ANDI:  ins = i_enc(im[11:0], 3'd7, 7'h13);
      K_SLLI:  ins = i_enc({7'h00, im[4:0]}, 3'd1, 7'h13);
      K_SRLI:  ins = i_enc({7'h00, im[4:0]}, 3'd5, 7'h13);
      K_SRAI:  ins = i_enc({7'h20, im[4:0]}, 3'd5, 7'h13);
      K_LUI:   ins = {im[31:12], 5'd3, 7'h37};
      K_AUIPC: ins = {im[31:12], 5'd3, 7'h17};
      K_LOAD:  ins = i_enc(im[11:0], 3'd2, 7'h03);
      K_STORE: ins = {im[11:5], 5'd2, 5'd1, 3'd2, im[4:0], 7'h23};
      K_JAL:   ins = {im[20], im[10:1], im[11], im[19:12], 5'd3, 7'h6f};
      K_JALR:  ins = i_enc(im[11:0], 3'd0, 7'h67);
      K_BEQ:   ins = b_enc(im, 3'd0);
      K_BNE:   ins = b_enc(im, 3'd1);
      K_BLT:   ins = b_enc(im, 3'd4);
      K_BGE:   ins = b_enc(im, 3'd5);
      K_BLTU:  ins = b_enc(im, 3'd6);
      K_BGEU:  ins = b_enc(im, 3'd7);
      K_BR010: ins = b_enc(im, 3'd2);
      K_BR011: ins = b_enc(im, 3'd3);
      default: ins = {rnd[31:7], 7'h0f};
    endcase
    return ins;
  endfunction

  // Reference model working on mnemonic and immediate value directly
  function automatic void model(input kind_e k, input logic [31:0] a, b, im, pc,
                                output logic [31:0] res, output logic br, output logic [31:0] tgt);
    res = 32'h0; br = 1'b0; tgt = pc + im;
    case (k)
      K_ADD:   res = a + b;
      K_SUB:   res = a - b;
      K_SLL:   res = a << b[4:0];
      K_SLT:   res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      K_XOR:   res = a ^ b;
      K_SRL:   res = a >> b[4:0];
      K_SRA:   res = int'(a) >>> b[4:0];
      K_OR:    res = a | b;
      K_AND:   res = a & b;
      K_ADDI:  res = a + im;
      K_SLTI:  res = (int'(a) < int'(im)) ? 32'd1 : 32'd0;
      K_SLTIU: res = (a < im) ? 32'd1 : 32'd0;
      K_XORI:  res = a ^ im;
      K_ORI:   res = a | im;
      K_ANDI:  res = a & im;
      K_SLLI:  res = a << im[4:0];
      K_SRLI:  res = a >> im[4:0];
      K_SRAI:  res = int'(a) >>> im[4:0];
      K_LUI:   res = im;
      K_AUIPC: res = pc + im;
      K_LOAD, K_STORE: res = a + im;
      K_JAL:   begin res = pc + im; br = 1'b1; tgt = res; end
      K_JALR:  begin res = (a + im) & 32'hFFFF_FFFE; br = 1'b1; tgt = res; end
      K_BEQ:   br = (a == b);
      K_BNE:   br = (a != b);
      K_BLT:   br = (int'(a) < int'(b));
      K_BGE:   br = (int'(a) >= int'(b));
      K_BLTU:  br = (a < b);
      K_BGEU:  br = (a >= b);
      default: res = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input kind_e k);
    logic [31:0] r;
    logic [31:0] im;
    r = $urandom;
    case (k)
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_LOAD, K_STORE, K_JALR:
        im = {{20{r[11]}}, r[11:0]};
      K_SLLI, K_SRLI, K_SRAI: im = {27'h0, r[4:0]};
      K_LUI, K_AUIPC:         im = {r[19:0], 12'h0};
      K_JAL:                  im = {{11{r[19]}}, r[19:0], 1'b0};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_BR010, K_BR011:
        im = {{19{r[11]}}, r[11:0], 1'b0};
      default:                im = 32'h0;
    endcase
    return im;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return r;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic drive(input kind_e k, input logic [31:0] a, b, im, pc, rnd);
    instr_i = encode(k, im, rnd);
    pc_i    = pc;
    rs1_i   = a;
    rs2_i   = b;
    valid_i = 1'b1;
  endtask

  // One isolated instruction: accept, check the bundle, then an idle cycle
  // in which the redirect pulse must have cleared and the bundle drained.
  task automatic run_vec(input vec_t v, input string nm, input logic [31:0] rnd);
    logic [31:0] ins;
    drive(v.k, v.a, v.b, v.imm, v.pc, rnd);
    ins    = instr_i;
    ack_i  = 1'b1;
    halt_i = 1'b0;
    #1 chk1({nm, " ack_o"}, ack_o, 1'b1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk1({nm, " valid_o"}, valid_o, 1'b1);
    chk({nm, " result_o"}, result_o, v.exp_res);
    chk({nm, " instr_o"}, instr_o, ins);
    chk({nm, " pc_o"}, pc_o, v.pc);
    chk({nm, " rs2_o"}, rs2_o, v.b);
    chk1({nm, " branch_o"}, branch_o, v.exp_br);
    if (v.exp_br) chk({nm, " branch_target_o"}, branch_target_o, v.exp_tgt);
    @(posedge clk); #1;
    chk1({nm, " branch_o clears"}, branch_o, 1'b0);
    chk1({nm, " valid_o drains"}, valid_o, 1'b0);
    $display("vec %s instr=%h res=%h br=%b", nm, ins, v.exp_res, v.exp_br);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; halt_i = 1'b0; valid_i = 1'b0; ack_i = 1'b0;
    instr_i = 32'h0; pc_i = 32'h0; rs1_i = 32'h0; rs2_i = 32'h0;

    // Directed vectors with hand-computed expectations
    tbl.push_back(mk(K_SUB,   32'h0,        32'h1,  32'h0,        32'h10,  32'hFFFF_FFFF, 1'b0, 32'h0));
    tbl.push_back(mk(K_SRA,   32'h8000_0000, 32'd31, 32'h0,       32'h14,  32'hFFFF_FFFF, 1'b0, 32'h0));
    tbl.push_back(mk(K_SLT,   32'hFFFF_FFFF, 32'h1, 32'h0,        32'h18,  32'h1,         1'b0, 32'h0));
    tbl.push_back(mk(K_SLTU,  32'hFFFF_FFFF, 32'h1, 32'h0,        32'h1C,  32'h0,         1'b0, 32'h0));
    tbl.push_back(mk(K_SRAI,  32'h8000_0000, 32'h0, 32'h4,        32'h20,  32'hF800_0000, 1'b0, 32'h0));
    tbl.push_back(mk(K_SRL,   32'hFFFF_FFFF, 32'h24, 32'h0,       32'h24,  32'h0FFF_FFFF, 1'b0, 32'h0));
    tbl.push_back(mk(K_ADDI,  32'h5,        32'h9,  32'hFFFF_FFFA, 32'h28, 32'hFFFF_FFFF, 1'b0, 32'h0));
    tbl.push_back(mk(K_SLTIU, 32'h0,        32'h0,  32'hFFFF_FFFF, 32'h2C, 32'h1,         1'b0, 32'h0));
    tbl.push_back(mk(K_JALR,  32'h2003,     32'h0,  32'h4,        32'h40,  32'h2006,      1'b1, 32'h2006));
    tbl.push_back(mk(K_LOAD,  32'h1000,     32'h0,  32'hFFFF_FFFC, 32'h44, 32'hFFC,       1'b0, 32'h0));
    tbl.push_back(mk(K_STORE, 32'h100,      32'hABCD, 32'h7FF,    32'h48,  32'h8FF,       1'b0, 32'h0));
    tbl.push_back(mk(K_LUI,   32'h0,        32'h0,  32'h1234_5000, 32'h4C, 32'h1234_5000, 1'b0, 32'h0));
    tbl.push_back(mk(K_AUIPC, 32'h0,        32'h0,  32'hFFFF_F000, 32'h1000, 32'h0,       1'b0, 32'h0));
    tbl.push_back(mk(K_JAL,   32'h0,        32'h0,  32'h800,      32'h200, 32'hA00,       1'b1, 32'hA00));
    tbl.push_back(mk(K_BEQ,   32'h3,        32'h3,  32'hFFFF_FFF8, 32'h100, 32'h0,        1'b1, 32'hF8));
    tbl.push_back(mk(K_BNE,   32'h3,        32'h3,  32'hFFFF_FFF8, 32'h100, 32'h0,        1'b0, 32'h0));
    tbl.push_back(mk(K_BLT,   32'hFFFF_FFFF, 32'h1, 32'h10,       32'h300, 32'h0,         1'b1, 32'h310));
    tbl.push_back(mk(K_BGEU,  32'hFFFF_FFFF, 32'h1, 32'h10,       32'h300, 32'h0,         1'b1, 32'h310));
    tbl.push_back(mk(K_BLTU,  32'hFFFF_FFFF, 32'h1, 32'h10,       32'h300, 32'h0,         1'b0, 32'h0));
    tbl.push_back(mk(K_BR010, 32'h3,        32'h3,  32'h10,       32'h300, 32'h0,         1'b0, 32'h0));
    tbl.push_back(mk(K_OTHER, 32'h55,       32'h66, 32'h0,        32'h304, 32'h0,         1'b0, 32'h0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("reset valid_o", valid_o, 1'b0);
    chk1("reset branch_o", branch_o, 1'b0);
    chk("reset instr_o", instr_o, 32'h0);
    chk("reset result_o", result_o, 32'h0);
    chk("reset rs2_o", rs2_o, 32'h0);
    chk("reset pc_o", pc_o, 32'h0);
    chk("reset branch_target_o", branch_target_o, 32'h0);
    rstn_i = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d %s", i, tbl[i].k.name()), 32'h1234_5600);

    // Back-to-back ADD with ack_i held: no bubbles
    ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(K_ADD, 32'd5, 32'd7, 32'h0, 32'h10 + 32'(4 * i), 32'h0);
      #1 chk1("b2b ack_o", ack_o, 1'b1);
      @(posedge clk); #1;
      chk1("b2b valid_o", valid_o, 1'b1);
      chk("b2b result_o", result_o, 32'd12);
      chk("b2b pc_o", pc_o, 32'h10 + 32'(4 * i));
      $display("b2b cycle %0d pc=%h", i, pc_o);
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk1("b2b drain valid_o", valid_o, 1'b0);

    // Back-pressure: bundle A held while B waits, then B accepted on ack_i
    drive(K_ADD, 32'd5, 32'd7, 32'h0, 32'h20, 32'h0);
    ack_i = 1'b1;
    @(posedge clk); #1;
    drive(K_SUB, 32'd9, 32'd4, 32'h0, 32'h24, 32'h0);
    ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk1("bp ack_o", ack_o, 1'b0);
      @(posedge clk); #1;
      chk1("bp valid_o", valid_o, 1'b1);
      chk("bp result_o", result_o, 32'd12);
      chk("bp pc_o", pc_o, 32'h20);
      $display("bp stall cycle %0d", i);
    end
    ack_i = 1'b1;
    #1 chk1("bp release ack_o", ack_o, 1'b1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk1("bp B valid_o", valid_o, 1'b1);
    chk("bp B result_o", result_o, 32'd5);
    chk("bp B pc_o", pc_o, 32'h24);
    @(posedge clk); #1;
    chk1("bp drain valid_o", valid_o, 1'b0);

    // Taken BEQ blocks the wrong-path instruction during the pulse
    drive(K_BEQ, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100, 32'h0);
    #1 chk1("flush ack_o beq", ack_o, 1'b1);
    @(posedge clk); #1;
    chk1("flush branch_o", branch_o, 1'b1);
    chk("flush branch_target_o", branch_target_o, 32'hF8);
    drive(K_ADD, 32'd1, 32'd1, 32'h0, 32'h104, 32'h0);
    #1 chk1("flush ack_o wrong-path", ack_o, 1'b0);
    @(posedge clk); #1;
    chk1("flush branch_o clears", branch_o, 1'b0);
    chk1("flush valid_o", valid_o, 1'b0);
    chk("flush pc_o held", pc_o, 32'h100);
    chk1("flush ack_o after pulse", ack_o, 1'b1);
    valid_i = 1'b0;
    @(posedge clk); #1;
    $display("flush sequence done");

    // Halt during a pending redirect stretches the pulse
    drive(K_BEQ, 32'd7, 32'd7, 32'h20, 32'h200, 32'h0);
    #1 chk1("halt ack_o beq", ack_o, 1'b1);
    @(posedge clk); #1;
    chk1("halt branch_o set", branch_o, 1'b1);
    halt_i = 1'b1;
    drive(K_ADD, 32'd1, 32'd2, 32'h0, 32'h300, 32'h0);
    #1 chk1("halt ack_o", ack_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk1("halt branch_o held", branch_o, 1'b1);
      chk("halt target held", branch_target_o, 32'h220);
      chk1("halt valid_o held", valid_o, 1'b1);
      chk("halt pc_o held", pc_o, 32'h200);
      $display("halt cycle %0d", i);
    end
    halt_i = 1'b0;
    #1 chk1("halt release branch_o", branch_o, 1'b1);
    chk1("halt release ack_o", ack_o, 1'b0);
    @(posedge clk); #1;
    chk1("halt after branch_o", branch_o, 1'b0);
    chk1("halt after valid_o", valid_o, 1'b0);
    valid_i = 1'b0;
    // Halt with an empty stage: nothing is consumed
    halt_i = 1'b1;
    drive(K_ADD, 32'd1, 32'd2, 32'h0, 32'h304, 32'h0);
    #1 chk1("halt idle ack_o", ack_o, 1'b0);
    @(posedge clk); #1;
    chk1("halt idle valid_o", valid_o, 1'b0);
    halt_i = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-bundle, no clock edge needed
    drive(K_ADD, 32'd5, 32'd7, 32'h0, 32'h40, 32'h0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk1("arst pre valid_o", valid_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1 chk1("arst valid_o", valid_o, 1'b0);
    chk("arst result_o", result_o, 32'h0);
    chk("arst pc_o", pc_o, 32'h0);
    #3 rstn_i = 1'b1;
    @(posedge clk); #1;
    // Reset during a redirect pulse cancels it
    drive(K_JAL, 32'h0, 32'h0, 32'h40, 32'h80, 32'h0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk1("arst jal branch_o", branch_o, 1'b1);
    rstn_i = 1'b0;
    #1 chk1("arst branch_o", branch_o, 1'b0);
    chk("arst branch_target_o", branch_target_o, 32'h0);
    #3 rstn_i = 1'b1;
    @(posedge clk); #1;
    chk1("arst post branch_o", branch_o, 1'b0);
    $display("async reset sequence done");

    // Random instructions against the reference model
    for (int i = 0; i < 300; i++) begin
      vec_t        v;
      logic [31:0] r, er, et, pcr;
      logic        eb;
      v.k = kind_e'($urandom_range(0, 33));
      v.a = pick();
      v.b = ($urandom_range(0, 3) == 0) ? v.a : pick();
      v.imm = gen_imm(v.k);
      pcr = $urandom;
      v.pc = {pcr[31:2], 2'b00};
      model(v.k, v.a, v.b, v.imm, v.pc, er, eb, et);
      v.exp_res = er; v.exp_br = eb; v.exp_tgt = et;
      r = $urandom;
      run_vec(v, $sformatf("rnd%0d %s", i, v.k.name()), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
